// File: rtl/uart_tx_word_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_word_feeder
//
// Purpose:
//   This is the upstream feeder for the UART byte transmitter in the MIPS
//   debug path. It queues 32-bit debug words in a small circular FIFO. It then
//   hands the bytes of each word to the transmitter, least-significant byte
//   first, using a level-based ready/done handshake.
//
// Ports:
//   clk          system clock (only clock)
//   reset        asynchronous, active-high reset
//   i_wr         push i_word this cycle
//   i_word       word to send (DATA_BITS*WORD_BYTES bits)
//   o_full       FIFO holds FIFO_DEPTH words
//   o_empty      FIFO holds no words
//   o_overflow   one-cycle pulse after a push was dropped because the FIFO was full
//   o_busy       FSM not idle, or words still queued
//   o_tx_ready   registered request: byte on o_tx_data is valid
//   o_tx_data    registered byte to transmit
//   i_tx_done    transmitter idle flag (falls when a frame starts, rises when idle)
// ---------------------------------------------------------------------------
module uart_tx_word_feeder #(
  parameter int DATA_BITS  = 8,
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_wr,
  input  logic [DATA_BITS*WORD_BYTES-1:0] i_word,
  output logic                            o_full,
  output logic                            o_empty,
  output logic                            o_overflow,
  output logic                            o_busy,
  output logic                            o_tx_ready,
  output logic [DATA_BITS-1:0]            o_tx_data,
  input  logic                            i_tx_done
);

  localparam int WORD_W = DATA_BITS * WORD_BYTES;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RELEASE
  } state_t;

  state_t               r_state;
  logic [WORD_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [WORD_W-1:0]    r_word;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_overflow;
  logic                 r_tx_ready;
  logic [DATA_BITS-1:0] r_tx_data;

  logic                 w_push;
  logic                 w_pop;
  logic [WORD_W-1:0]    w_head;
  logic [IDX_W-1:0]     w_idx_next;
  logic [DATA_BITS-1:0] w_word_bytes [WORD_BYTES];

  // Flags come straight from the registered count, so they never glitch on inputs.
  assign o_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != ST_IDLE) || !o_empty;
  assign o_tx_ready = r_tx_ready;
  assign o_tx_data  = r_tx_data;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign w_push     = i_wr && !o_full;
  assign w_pop      = (r_state == ST_IDLE) && !o_empty;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_idx_next = r_idx + IDX_W'(1);

  // Split the held word into a byte array so the next byte is a plain index.
  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_bytes
    assign w_word_bytes[g] = r_word[g*DATA_BITS +: DATA_BITS];
  end

  // Storage needs no reset: reset clears the count and the pointers, which
  // makes every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_word;
    end
  end

  // FIFO bookkeeping. Pointers wrap naturally because the depth is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_wr && o_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Byte sequencer. The byte is loaded into o_tx_data only when the FSM
  // enters SEND. The head word's low byte is used directly on the pop, because
  // r_word is loaded on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_idx      <= '0;
      r_tx_ready <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_word     <= w_head;
            r_idx      <= '0;
            r_tx_data  <= w_head[DATA_BITS-1:0];
            r_tx_ready <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A falling done flag means the transmitter has latched the byte.
          if (!i_tx_done) begin
            r_tx_ready <= 1'b0;
            r_state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (i_tx_done) begin
            if (r_idx == IDX_LAST) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx      <= w_idx_next;
              r_tx_data  <= w_word_bytes[w_idx_next];
              r_tx_ready <= 1'b1;
              r_state    <= ST_SEND;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_word_feeder
//
// Directed bench for uart_tx_word_feeder. It includes a behavioural byte
// transmitter that can also drive a serial line (4 clocks per bit), and a
// line receiver that decodes the frames back into bytes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_word_feeder;

  localparam int DATA_BITS  = 8;
  localparam int WORD_BYTES = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CLKS   = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        iWr   = 1'b0;
  logic [31:0] iWord = '0;
  logic        oFull, oEmpty, oOverflow, oBusy, oTxReady;
  logic [7:0]  oTxData;
  logic        txDone;

  int assertCount = 0;
  int failCount   = 0;

  typedef enum {M_IDLE, M_WAIT_DROP, M_FRAME, M_WAIT_REL, M_WAIT_RISE} model_t;
  model_t      mState;
  int          mCnt;
  bit          stall        = 1'b0;
  bit          serialMode   = 1'b0;
  bit          randomDelays = 1'b0;
  int          riseCount    = 0;
  logic [7:0]  sentQ[$];
  logic [31:0] expQ[$];
  logic        serialLine;
  logic [9:0]  frameBits;
  int          bitIdx;
  int          baudCnt;
  logic [7:0]  rxQ[$];
  logic [7:0]  rxByte;
  int          frameErrors  = 0;

  uart_tx_word_feeder #(
    .DATA_BITS (DATA_BITS),
    .WORD_BYTES(WORD_BYTES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_wr      (iWr),
    .i_word    (iWord),
    .o_full    (oFull),
    .o_empty   (oEmpty),
    .o_overflow(oOverflow),
    .o_busy    (oBusy),
    .o_tx_ready(oTxReady),
    .o_tx_data (oTxData),
    .i_tx_done (txDone)
  );

  always #5 clk = ~clk;

  // Behavioural transmitter. It is driven on the falling edge so that the DUT
  // samples stable levels. The done flag drops some cycles after a request,
  // and rises again some cycles after the request is withdrawn.
  initial begin
    txDone     = 1'b1;
    serialLine = 1'b1;
    mState     = M_IDLE;
    mCnt       = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mState     = M_IDLE;
        txDone     = 1'b1;
        serialLine = 1'b1;
      end else begin
        case (mState)
          M_IDLE: begin
            if (oTxReady && !stall) begin
              mCnt   = randomDelays ? int'($urandom_range(1, 6)) : 3;
              mState = M_WAIT_DROP;
            end
          end
          M_WAIT_DROP: begin
            mCnt--;
            if (mCnt <= 0) begin
              txDone = 1'b0;
              sentQ.push_back(oTxData);
              if (serialMode) begin
                frameBits  = {1'b1, oTxData, 1'b0};
                bitIdx     = 0;
                baudCnt    = 0;
                serialLine = frameBits[0];
                mState     = M_FRAME;
              end else begin
                mState = M_WAIT_REL;
              end
            end
          end
          M_FRAME: begin
            baudCnt++;
            if (baudCnt == BIT_CLKS) begin
              baudCnt = 0;
              bitIdx++;
              if (bitIdx == 10) begin
                serialLine = 1'b1;
                mState     = M_WAIT_REL;
              end else begin
                serialLine = frameBits[bitIdx];
              end
            end
          end
          M_WAIT_REL: begin
            if (!oTxReady) begin
              mCnt   = randomDelays ? int'($urandom_range(1, 6)) : 5;
              mState = M_WAIT_RISE;
            end
          end
          M_WAIT_RISE: begin
            mCnt--;
            if (mCnt <= 0) begin
              txDone = 1'b1;
              riseCount++;
              mState = M_IDLE;
            end
          end
          default: mState = M_IDLE;
        endcase
      end
    end
  end

  // Serial line receiver. It samples near the middle of each bit and flags
  // a bad start or stop bit.
  initial begin
    forever begin
      @(posedge clk);
      if (serialLine == 1'b0) begin
        repeat (BIT_CLKS/2) @(posedge clk);
        if (serialLine !== 1'b0) frameErrors++;
        for (int b = 0; b < 8; b++) begin
          repeat (BIT_CLKS) @(posedge clk);
          rxByte[b] = serialLine;
        end
        repeat (BIT_CLKS) @(posedge clk);
        if (serialLine !== 1'b1) frameErrors++;
        rxQ.push_back(rxByte);
      end
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    @(negedge clk);
    iWr   = 1'b1;
    iWord = word;
    @(negedge clk);
    iWr   = 1'b0;
  endtask

  task automatic pushBurst(input logic [31:0] firstWord, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      iWr   = 1'b1;
      iWord = firstWord + 32'(k);
    end
    @(negedge clk);
    iWr = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"},    32'(oTxReady),  0);
    checkOutput({tag, "_data"},     32'(oTxData),   0);
    checkOutput({tag, "_full"},     32'(oFull),     0);
    checkOutput({tag, "_empty"},    32'(oEmpty),    1);
    checkOutput({tag, "_overflow"}, 32'(oOverflow), 0);
    checkOutput({tag, "_busy"},     32'(oBusy),     0);
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((oBusy || mState != M_IDLE) && n < maxCycles);
    checkOutput({tag, "_idle_timeout"}, 32'(oBusy || mState != M_IDLE), 0);
  endtask

  task automatic checkSentWords(input string tag);
    logic [31:0] got;
    checkOutput({tag, "_byte_count"}, 32'(sentQ.size()), 32'(expQ.size() * 4));
    for (int i = 0; i < expQ.size(); i++) begin
      got = '0;
      if (4*i + 3 < sentQ.size())
        got = {sentQ[4*i+3], sentQ[4*i+2], sentQ[4*i+1], sentQ[4*i]};
      checkOutput($sformatf("%s_word%0d", tag, i), got, expQ[i]);
    end
  endtask

  // Global watchdog so that the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] t2Exp [4];
    int n;
    int readyHigh;
    t2Exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    $display("[TB] reset");
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("rst0");
    reset = 1'b0;

    // Test 1: single word, latency, inter-byte gap, busy release.
    $display("[TB] single word");
    sentQ.delete();
    riseCount = 0;
    applyStimulus(32'h11223344);
    checkOutput("t1_empty_after_push", 32'(oEmpty),   0);
    checkOutput("t1_busy_after_push",  32'(oBusy),    1);
    checkOutput("t1_ready_latency1",   32'(oTxReady), 0);
    @(negedge clk);
    checkOutput("t1_ready_latency2",   32'(oTxReady), 1);
    checkOutput("t1_first_byte",       32'(oTxData),  32'h44);
    n = 0;
    while (riseCount < 1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t1_gap_ready",     32'(oTxReady), 1);
    checkOutput("t1_second_byte",   32'(oTxData),  32'h33);
    waitIdle("t1", 500);
    checkOutput("t1_rises_at_idle", 32'(riseCount), 4);
    expQ = '{32'h11223344};
    checkSentWords("t1");

    // Test 2: serial frames through the line receiver.
    $display("[TB] serial line");
    serialMode = 1'b1;
    sentQ.delete();
    rxQ.delete();
    frameErrors = 0;
    applyStimulus(32'hDEADBEEF);
    waitIdle("t2", 2000);
    repeat (10) @(posedge clk);
    checkOutput("t2_frame_count", 32'(rxQ.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rxQ.size())
        checkOutput($sformatf("t2_rx%0d", i), 32'(rxQ[i]), 32'(t2Exp[i]));
    end
    checkOutput("t2_frame_errors", 32'(frameErrors), 0);
    serialMode = 1'b0;

    // Test 3: fill, overflow, and drain order.
    $display("[TB] fill and overflow");
    sentQ.delete();
    stall = 1'b1;
    applyStimulus(32'hA55A_C33C);
    repeat (2) @(negedge clk);
    checkOutput("t3_head_popped", 32'(oEmpty),   1);
    checkOutput("t3_stalled_req", 32'(oTxReady), 1);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 8) checkOutput("t3_not_full_at7", 32'(oFull), 0);
      if (i == 9) begin
        checkOutput("t3_full_at8",      32'(oFull),     1);
        checkOutput("t3_no_early_ovf",  32'(oOverflow), 0);
      end
      iWr   = 1'b1;
      iWord = 32'(i);
    end
    @(negedge clk);
    iWr = 1'b0;
    checkOutput("t3_overflow_pulse", 32'(oOverflow), 1);
    @(negedge clk);
    checkOutput("t3_overflow_1cyc",  32'(oOverflow), 0);
    checkOutput("t3_still_full",     32'(oFull),     1);
    stall = 1'b0;
    waitIdle("t3", 4000);
    expQ = '{32'hA55A_C33C, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    checkSentWords("t3");

    // Test 4: push in the same cycle as the pop.
    $display("[TB] simultaneous push and pop");
    sentQ.delete();
    @(negedge clk);
    iWr   = 1'b1;
    iWord = 32'h01020304;
    @(negedge clk);
    checkOutput("t4_count_before", 32'(dut.r_count), 1);
    iWord = 32'hA0B0C0D0;
    @(negedge clk);
    iWr = 1'b0;
    checkOutput("t4_count_same",  32'(dut.r_count), 1);
    checkOutput("t4_ready",       32'(oTxReady),    1);
    checkOutput("t4_first_byte",  32'(oTxData),     32'h04);
    waitIdle("t4", 1000);
    expQ = '{32'h01020304, 32'hA0B0C0D0};
    checkSentWords("t4");

    // Test 5: pointer wrap with bursts and random handshake delays.
    $display("[TB] wrap-around");
    randomDelays = 1'b1;
    sentQ.delete();
    expQ.delete();
    for (int w = 0; w < 20; w += 3) begin
      pushBurst(32'h100 + 32'(w), (20 - w < 3) ? (20 - w) : 3);
      n = 0;
      while (!oEmpty && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput($sformatf("t5_drain_timeout%0d", w), 32'(oEmpty), 1);
    end
    for (int w = 0; w < 20; w++) expQ.push_back(32'h100 + 32'(w));
    waitIdle("t5", 2000);
    checkSentWords("t5");
    checkOutput("t5_final_count", 32'(dut.r_count), 0);
    checkOutput("t5_final_empty", 32'(oEmpty),      1);
    randomDelays = 1'b0;

    // Test 6: reset while releasing byte 2 of a word, with 3 words queued.
    $display("[TB] reset mid-word");
    sentQ.delete();
    applyStimulus(32'hCAFEF00D);
    pushBurst(32'h7000, 3);
    n = 0;
    while (!(sentQ.size() == 3 && !oTxReady) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t6_reached_byte2", 32'(sentQ.size()), 3);
    if (sentQ.size() >= 3) checkOutput("t6_byte2_value", 32'(sentQ[2]), 32'hFE);
    checkOutput("t6_queued", 32'(dut.r_count), 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetState("t6_rst_held");
    @(negedge clk);
    reset = 1'b0;
    checkResetState("t6_rst_released");
    readyHigh = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (oTxReady) readyHigh++;
    end
    checkOutput("t6_no_ready_after_reset", 32'(readyHigh), 0);
    sentQ.delete();
    applyStimulus(32'h00000055);
    waitIdle("t6", 1000);
    expQ = '{32'h00000055};
    checkSentWords("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_feeder.md
# uart_tx_word_feeder

Upstream feeder for the UART transmitter in the MIPS debug path. It accepts 32-bit words (register, PC and memory dumps) from the debug unit and buffers them in a small word FIFO. It splits each word into bytes, least-significant byte first. Bytes are handed to the byte transmitter through its ready/done handshake (`o_tx_ready`/`o_tx_data` out, `i_tx_done` in).

## Interface

Parameters:
- `DATA_BITS`, 8: bits per UART byte; must match the transmitter.
- `WORD_BYTES`, 4: bytes per word; word width is `DATA_BITS*WORD_BYTES`.
- `FIFO_DEPTH`, 8: word FIFO depth; must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_wr`, in, 1: push `i_word` this cycle.
- `i_word`, in, `DATA_BITS*WORD_BYTES`: word to send.
- `o_full`, out, 1: FIFO holds `FIFO_DEPTH` words.
- `o_empty`, out, 1: FIFO holds 0 words.
- `o_overflow`, out, 1: one-cycle pulse when a push is dropped.
- `o_busy`, out, 1: FSM not in IDLE, or FIFO not empty.
- `o_tx_ready`, out, 1: byte on `o_tx_data` is valid; request to transmit.
- `o_tx_data`, out, `DATA_BITS`: byte to transmit.
- `i_tx_done`, in, 1: transmitter idle/complete flag.
  - Reads 1 when the transmitter is idle.
  - Falls once a frame has started.
  - Rises again only when the transmitter is idle and `o_tx_ready` is 0.

## Operation

FIFO:
- Circular buffer with read pointer, write pointer and an occupancy count of width `$clog2(FIFO_DEPTH)+1`. Pointers wrap modulo `FIFO_DEPTH`.
- `o_full` = count==`FIFO_DEPTH`; `o_empty` = count==0. Both are decoded from the registered count.
- Push when `i_wr` && !`o_full`.
- `i_wr` while `o_full` drops the word, leaves FIFO contents unchanged, and pulses `o_overflow` high the next cycle. This holds even if a pop happens in the same cycle.
- A push and a pop in the same cycle leave the count unchanged; both pointers advance.

Registers:
- Word register: `WORD_BYTES*DATA_BITS` bits.
- Byte index: `$clog2(WORD_BYTES)` bits, minimum 1.

FSM states: IDLE, SEND, RELEASE.
- **IDLE**: if count!=0, pop the head word into the word register, set byte index to 0, and go to SEND. Otherwise stay in IDLE.
- **SEND**: `o_tx_ready`=1 and `o_tx_data`=byte[index] of the word register. Stay until `i_tx_done`==0, which means the frame has started; then go to RELEASE.
- **RELEASE**: `o_tx_ready`=0; `o_tx_data` holds its value. Stay until `i_tx_done`==1. Then:
  - if index==`WORD_BYTES-1`, go to IDLE;
  - otherwise increment the index and go to SEND.

Output rules:
- `o_tx_ready` and `o_tx_data` are registered. There is no combinational path from any input to them.
- `o_tx_data` changes only on the transition into SEND.
- Byte order on the wire: bits [7:0] first, then [15:8], and so on.
- Reset values: FSM in IDLE, count 0, pointers 0, word register 0, index 0, `o_tx_ready` 0, `o_tx_data` 0, `o_full` 0, `o_empty` 1, `o_overflow` 0, `o_busy` 0.
- Reset mid-word aborts the word and clears the FIFO. No further `o_tx_ready` is issued until new data is pushed.

## Timing

- Push at edge N into an empty FIFO while in IDLE:
  - count=1 and `o_empty`=0 after edge N.
  - Pop at edge N+1.
  - `o_tx_ready`=1 with byte 0 valid after edge N+1. Latency is 2 cycles.
- `o_busy` goes high after edge N and stays high until the FSM is back in IDLE with an empty FIFO.
- Inter-byte gap from the `i_tx_done` rise: RELEASE→SEND takes 1 cycle, so `o_tx_ready` is high again after the first edge at which `i_tx_done`==1 is sampled.
- Word-to-word gap: 1 extra cycle through IDLE (IDLE→SEND 1 cycle, no dead cycles).
- `i_tx_done` is sampled only in SEND and RELEASE. Its level in IDLE is ignored.
- A transmitter baud tick slower than `clk` is tolerated: the handshake is level-based and `o_tx_ready`/`o_tx_data` hold indefinitely.

## Test plan

1. **Single word, behavioral model.** Reset, push 0x11223344. The transmitter model drops `i_tx_done` 3 cycles after `o_tx_ready` and raises it 5 cycles after `o_tx_ready` falls.
   - Bytes sent: 0x44, 0x33, 0x22, 0x11.
   - `o_tx_ready` rises 2 cycles after the push.
   - `o_busy` falls after the 4th `i_tx_done` rise.
2. **Real transmitter on the serial line.** Chain with the UART transmitter at `CLK_FREQ`=40, `BAUD_RATE`=10 and push 0xDEADBEEF.
   - Line decodes to 0xEF, 0xBE, 0xAD, 0xDE.
   - Each frame has start=0 and stop=1.
   - No frame is duplicated or skipped.
3. **Fill and overflow.** Stall `i_tx_done` high-but-never-falling so the first word sits in SEND, then push 9 more words (0x1..0x9).
   - `o_full`=1 after the 8th of these pushes.
   - The push of 0x9 pulses `o_overflow` for exactly 1 cycle.
   - After releasing the stall, the transmitted word sequence is the first word, then 0x1..0x8; 0x9 is never sent.
4. **Simultaneous push and pop.** FIFO at count=1 in IDLE, push in the same cycle as the pop.
   - Count stays 1.
   - Both words are sent in order.
5. **Pointer wrap-around.** Push/drain 20 words (0x100+i) in bursts of 3 with random `i_tx_done` delays.
   - Every word is received in order.
   - Final count=0 and `o_empty`=1.
6. **Reset mid-word.** Assert reset while in RELEASE on byte 2 of 0xCAFEF00D with 3 words queued.
   - All outputs return to their reset values.
   - No `o_tx_ready` until a new push.
   - A post-reset push of 0x00000055 sends 0x55, 0x00, 0x00, 0x00.
